// File: rtl/mux8_1_using4_1_and2_1_pkg.sv
// Shared select typedef for the 8:1 selector tree: index is {s2,s1,s0}.
package mux8_1_using4_1_and2_1_pkg;
  localparam int SEL_W = 3;
  typedef logic [SEL_W-1:0] sel_t;
endpackage

// File: rtl/mux8_1_using4_1_and2_1_mux4_1_cell.sv
// Combinational 4:1 selector cell, zero latency, no backpressure.
module mux4_1_cell #(
  parameter int WIDTH = 1
) (
  input  logic [WIDTH-1:0] a0,
  input  logic [WIDTH-1:0] a1,
  input  logic [WIDTH-1:0] a2,
  input  logic [WIDTH-1:0] a3,
  input  logic             s1,
  input  logic             s0,
  output logic [WIDTH-1:0] y
);

  always_comb begin
    y = a0;
    case ({s1, s0})
      2'd1:    y = a1;
      2'd2:    y = a2;
      2'd3:    y = a3;
      default: y = a0;
    endcase
  end

endmodule

// File: rtl/mux8_1_using4_1_and2_1.sv
// 8:1 selector as two 4:1 cells plus a 2:1 stage, registered output.
// Latency one clk cycle; no handshake or backpressure.
module mux8_1_using4_1_and2_1
  import mux8_1_using4_1_and2_1_pkg::*;
#(
  parameter int WIDTH = 1
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [WIDTH-1:0] d0,
  input  logic [WIDTH-1:0] d1,
  input  logic [WIDTH-1:0] d2,
  input  logic [WIDTH-1:0] d3,
  input  logic [WIDTH-1:0] d4,
  input  logic [WIDTH-1:0] d5,
  input  logic [WIDTH-1:0] d6,
  input  logic [WIDTH-1:0] d7,
  input  logic             s1,
  input  logic             s0,
  input  logic             s2,
  output logic [WIDTH-1:0] y
);

  sel_t             w_sel;
  logic [WIDTH-1:0] w_lo;
  logic [WIDTH-1:0] w_hi;
  logic [WIDTH-1:0] w_tree;
  logic [WIDTH-1:0] r_y;

  assign w_sel = {s2, s1, s0};

  mux4_1_cell #(.WIDTH(WIDTH)) u_lo (
    .a0(d0), .a1(d1), .a2(d2), .a3(d3),
    .s1(w_sel[1]), .s0(w_sel[0]), .y(w_lo)
  );

  mux4_1_cell #(.WIDTH(WIDTH)) u_hi (
    .a0(d4), .a1(d5), .a2(d6), .a3(d7),
    .s1(w_sel[1]), .s0(w_sel[0]), .y(w_hi)
  );

  assign w_tree = w_sel[2] ? w_hi : w_lo;

  // Reset wins over data regardless of the selects.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_y <= '0;
    end else begin
      r_y <= w_tree;
    end
  end

  assign y = r_y;

endmodule

// File: tb/tb_mux8_1_using4_1_and2_1.sv
// Scoreboard bench: a 1-bit and an 8-bit instance share clock, reset and selects.
module tb_mux8_1_using4_1_and2_1;

  logic       clk = 1'b0;
  logic       rst;
  logic [2:0] sel;
  logic [7:0] dv1;
  logic [7:0] dv8 [8];
  logic [0:0] y1;
  logic [7:0] y8;

  logic [0:0] exp1_q[$];
  logic [7:0] exp8_q[$];
  logic [0:0] last1;
  logic [7:0] last8;
  bit         have_last = 1'b0;

  int n_vec = 0;
  int n_bad = 0;

  always #5 clk = ~clk;

  mux8_1_using4_1_and2_1 #(.WIDTH(1)) dut1 (
    .clk(clk), .rst(rst),
    .d0(dv1[0]), .d1(dv1[1]), .d2(dv1[2]), .d3(dv1[3]),
    .d4(dv1[4]), .d5(dv1[5]), .d6(dv1[6]), .d7(dv1[7]),
    .s1(sel[1]), .s0(sel[0]), .s2(sel[2]),
    .y(y1)
  );

  mux8_1_using4_1_and2_1 #(.WIDTH(8)) dut8 (
    .clk(clk), .rst(rst),
    .d0(dv8[0]), .d1(dv8[1]), .d2(dv8[2]), .d3(dv8[3]),
    .d4(dv8[4]), .d5(dv8[5]), .d6(dv8[6]), .d7(dv8[7]),
    .s1(sel[1]), .s0(sel[0]), .s2(sel[2]),
    .y(y8)
  );

  task automatic check(input string tag, input logic [7:0] got, input logic [7:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got %h expected %h (sel=%0d rst=%b)", tag, got, exp, sel, rst);
    end
  endtask

  // Caller has driven inputs just after a rising edge; y must not move until the next one.
  task automatic step(input string tag);
    logic [0:0] e1;
    logic [7:0] e8;
    e1 = rst ? 1'b0 : dv1[sel];
    e8 = rst ? 8'h00 : dv8[sel];
    exp1_q.push_back(e1);
    exp8_q.push_back(e8);
    #2;
    if (have_last) begin
      check({tag, "_hold_w1"}, {7'b0, y1}, {7'b0, last1});
      check({tag, "_hold_w8"}, y8, last8);
    end
    @(posedge clk);
    #1;
    last1 = exp1_q.pop_front();
    last8 = exp8_q.pop_front();
    have_last = 1'b1;
    check({tag, "_w1"}, {7'b0, y1}, {7'b0, last1});
    check({tag, "_w8"}, y8, last8);
  endtask

  task automatic set_pattern();
    for (int k = 0; k < 8; k++) dv8[k] = 8'((k + 1) * 16 + k);
  endtask

  logic [7:0] row_d   [8] = '{8'h00, 8'hD0, 8'h38, 8'h50, 8'h28, 8'h88, 8'h48, 8'hFF};
  logic [2:0] row_sel [8] = '{3'd0, 3'd4, 3'd2, 3'd6, 3'd1, 3'd5, 3'd3, 3'd7};
  logic       row_y   [8] = '{1'b0, 1'b1, 1'b0, 1'b1, 1'b0, 1'b0, 1'b1, 1'b1};

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog expired");
  end

  initial begin
    rst = 1'b1;
    sel = 3'd7;
    dv1 = 8'hFF;
    set_pattern();
    @(posedge clk);
    #1;
    step("reset");
    rst = 1'b0;
    step("reset_release");

    for (int r = 0; r < 8; r++) begin
      dv1 = row_d[r];
      sel = row_sel[r];
      step("walk");
      check("walk_table", {7'b0, y1}, {7'b0, row_y[r]});
    end

    for (int k = 0; k < 8; k++) begin
      dv1 = 8'h01 << k;
      for (int s = 0; s < 8; s++) begin
        sel = 3'(s);
        step("onehot");
      end
    end

    dv1 = 8'hA5;
    for (int i = 0; i < 12; i++) begin
      sel = 3'($urandom_range(0, 7));
      step("track");
    end
    sel = 3'd2;
    repeat (3) step("hold");

    dv1 = 8'h80;
    sel = 3'd7;
    step("mid_pre");
    rst = 1'b1;
    step("mid_rst");
    rst = 1'b0;
    step("mid_post");

    set_pattern();
    dv1 = 8'h3C;
    for (int s = 0; s < 8; s++) begin
      sel = 3'(s);
      step("bytes");
      check("bytes_value", y8, 8'((s + 1) * 16 + s));
    end

    for (int i = 0; i < 30; i++) begin
      for (int k = 0; k < 8; k++) dv8[k] = 8'($urandom);
      dv1 = 8'($urandom);
      sel = 3'($urandom_range(0, 7));
      rst = ($urandom_range(0, 9) == 0);
      step("random");
    end
    rst = 1'b0;

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end

endmodule
